friscv_rv32i_encoder: RTL and testbench

//  Builds 32-bit RV32I instruction words from class + field commands; inverse of the
//  RV32I decoder. Used by the debug/self-test path to inject instructions and by

---
 rtl/friscv_rv32i_encoder.sv | 160 ++++++++++++++++
 tb/tb_friscv_rv32i_encoder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_rv32i_encoder.sv
// RV32I instruction encoder: turns class + field commands into 32-bit words
// and queues them, with an illegal-command flag, in a small output FIFO.
module friscv_rv32i_encoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            aclk,
  input  logic            srst,
  input  logic            enc_valid,
  output logic            enc_ready,
  input  logic [3:0]      enc_class,
  input  logic [2:0]      enc_funct3,
  input  logic [6:0]      enc_funct7,
  input  logic [4:0]      enc_rs1,
  input  logic [4:0]      enc_rs2,
  input  logic [4:0]      enc_rd,
  input  logic [XLEN-1:0] enc_imm,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic            inst_error,
  output logic [7:0]      err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_OPIMM  = 4'd7;
  localparam logic [3:0] CLS_OP     = 4'd8;
  localparam logic [3:0] CLS_FENCE  = 4'd9;
  localparam logic [3:0] CLS_FENCEI = 4'd10;
  localparam logic [3:0] CLS_ECALL  = 4'd11;
  localparam logic [3:0] CLS_EBREAK = 4'd12;
  localparam logic [3:0] CLS_CSR    = 4'd13;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] enc_word;
  logic            enc_err;
  logic            fits12, fits13, fits21, is_shift;

  logic [XLEN-1:0] mem_word [DEPTH];
  logic            mem_err  [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  // A value fits a signed N-bit field when every bit from N-1 upward matches the sign.
  assign fits12   = (&enc_imm[31:11]) | ~(|enc_imm[31:11]);
  assign fits13   = (&enc_imm[31:12]) | ~(|enc_imm[31:12]);
  assign fits21   = (&enc_imm[31:20]) | ~(|enc_imm[31:20]);
  assign is_shift = (enc_funct3 == 3'b001) || (enc_funct3 == 3'b101);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (enc_class)
      CLS_LUI, CLS_AUIPC: begin
        enc_word = {enc_imm[31:12], enc_rd, (enc_class == CLS_LUI) ? OPC_LUI : OPC_AUIPC};
        enc_err  = |enc_imm[11:0];
      end
      CLS_JAL: begin
        enc_word = {enc_imm[20], enc_imm[10:1], enc_imm[11], enc_imm[19:12], enc_rd, OPC_JAL};
        enc_err  = enc_imm[0] | ~fits21;
      end
      CLS_JALR: begin
        enc_word = {enc_imm[11:0], enc_rs1, 3'b000, enc_rd, OPC_JALR};
        enc_err  = ~fits12;
      end
      CLS_BRANCH: begin
        enc_word = {enc_imm[12], enc_imm[10:5], enc_rs2, enc_rs1, enc_funct3,
                    enc_imm[4:1], enc_imm[11], OPC_BRANCH};
        enc_err  = enc_imm[0] | ~fits13 | (enc_funct3 == 3'b010) | (enc_funct3 == 3'b011);
      end
      CLS_LOAD: begin
        enc_word = {enc_imm[11:0], enc_rs1, enc_funct3, enc_rd, OPC_LOAD};
        enc_err  = ~fits12 | (enc_funct3 == 3'b011) | (enc_funct3[2:1] == 2'b11);
      end
      CLS_STORE: begin
        enc_word = {enc_imm[11:5], enc_rs2, enc_rs1, enc_funct3, enc_imm[4:0], OPC_STORE};
        enc_err  = ~fits12 | (enc_funct3 >= 3'b011);
      end
      CLS_OPIMM: begin
        if (is_shift) begin
          enc_word = {enc_funct7, enc_imm[4:0], enc_rs1, enc_funct3, enc_rd, OPC_OPIMM};
          enc_err  = (|enc_imm[31:5]) |
                     ((enc_funct3 == 3'b001) ? (enc_funct7 != 7'h00)
                                             : ((enc_funct7 != 7'h00) && (enc_funct7 != 7'h20)));
        end else begin
          enc_word = {enc_imm[11:0], enc_rs1, enc_funct3, enc_rd, OPC_OPIMM};
          enc_err  = ~fits12;
        end
      end
      CLS_OP: begin
        enc_word = {enc_funct7, enc_rs2, enc_rs1, enc_funct3, enc_rd, OPC_OP};
        enc_err  = !((enc_funct7 == 7'h00) ||
                     ((enc_funct7 == 7'h20) && ((enc_funct3 == 3'b000) || (enc_funct3 == 3'b101))));
      end
      CLS_FENCE:  enc_word = {enc_imm[11:0], 13'd0, OPC_FENCE};
      CLS_FENCEI: enc_word = 32'h0000100F;
      CLS_ECALL:  enc_word = 32'h00000073;
      CLS_EBREAK: enc_word = 32'h00100073;
      CLS_CSR: begin
        enc_word = {enc_imm[11:0], enc_rs1, enc_funct3, enc_rd, OPC_SYSTEM};
        enc_err  = (enc_funct3 == 3'b000) || (enc_funct3 == 3'b100);
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = '0;
  end

  assign enc_ready   = (count != FULL_COUNT);
  assign inst_valid  = (count != '0);
  assign push        = enc_valid & enc_ready;
  assign pop         = inst_valid & inst_ready;
  // Gated so a flushed FIFO never exposes stale storage.
  assign instruction = inst_valid ? mem_word[rd_ptr] : '0;
  assign inst_error  = inst_valid & mem_err[rd_ptr];

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_word[wr_ptr] <= enc_word;
      mem_err[wr_ptr]  <= enc_err;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (push && enc_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_friscv_rv32i_encoder.sv
// Bench for friscv_rv32i_encoder: directed vector table, FIFO/reset/saturation
// sequences, and randomized traffic against an arithmetic reference model.
module tb_friscv_rv32i_encoder;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } cmd_t;

  typedef struct {
    cmd_t        cmd;
    logic [31:0] exp_word;
    logic        exp_err;
  } vector_t;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } entry_t;

  logic        aclk = 1'b0;
  logic        srst = 1'b1;
  logic        enc_valid = 1'b0;
  logic        enc_ready;
  logic [3:0]  enc_class = '0;
  logic [2:0]  enc_funct3 = '0;
  logic [6:0]  enc_funct7 = '0;
  logic [4:0]  enc_rs1 = '0;
  logic [4:0]  enc_rs2 = '0;
  logic [4:0]  enc_rd = '0;
  logic [31:0] enc_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic        inst_error;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  friscv_rv32i_encoder #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .srst(srst),
    .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_class(enc_class), .enc_funct3(enc_funct3), .enc_funct7(enc_funct7),
    .enc_rs1(enc_rs1), .enc_rs2(enc_rs2), .enc_rd(enc_rd), .enc_imm(enc_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_error(inst_error), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  function automatic cmd_t mk(input int cls, input int f3, input int f7, input int rs1,
                              input int rs2, input int rd, input logic [31:0] imm);
    cmd_t c;
    c.cls = 4'(cls); c.f3 = 3'(f3); c.f7 = 7'(f7);
    c.rs1 = 5'(rs1); c.rs2 = 5'(rs2); c.rd = 5'(rd); c.imm = imm;
    return c;
  endfunction

  function automatic logic [31:0] fld(input logic [31:0] v, input int lsb);
    return v << lsb;
  endfunction

  // Reference encoder built from shifts, masks and signed range arithmetic.
  function automatic void model_encode(input cmd_t c, output logic [31:0] w, output logic e);
    int signed   s;
    logic [31:0] u;
    bit          r12;
    s   = signed'(c.imm);
    u   = c.imm;
    r12 = (s < -2048) || (s > 2047);
    w = '0; e = 1'b0;
    case (int'(c.cls))
      0, 1: begin
        w = (u & 32'hFFFFF000) | fld(c.rd, 7) | ((c.cls == 4'd0) ? 32'h37 : 32'h17);
        e = (u % 4096) != 0;
      end
      2: begin
        w = fld((u >> 20) & 1, 31) | fld((u >> 1) & 32'h3FF, 21) | fld((u >> 11) & 1, 20) |
            fld((u >> 12) & 32'hFF, 12) | fld(c.rd, 7) | 32'h6F;
        e = (s % 2 != 0) || (s < -(1 << 20)) || (s >= (1 << 20));
      end
      3: begin
        w = fld(u & 32'hFFF, 20) | fld(c.rs1, 15) | fld(c.rd, 7) | 32'h67;
        e = r12;
      end
      4: begin
        w = fld((u >> 12) & 1, 31) | fld((u >> 5) & 32'h3F, 25) | fld(c.rs2, 20) |
            fld(c.rs1, 15) | fld(c.f3, 12) | fld((u >> 1) & 32'hF, 8) |
            fld((u >> 11) & 1, 7) | 32'h63;
        e = (s % 2 != 0) || (s < -4096) || (s > 4095) || (c.f3 == 3'd2) || (c.f3 == 3'd3);
      end
      5: begin
        w = fld(u & 32'hFFF, 20) | fld(c.rs1, 15) | fld(c.f3, 12) | fld(c.rd, 7) | 32'h03;
        e = r12 || (c.f3 == 3'd3) || (c.f3 == 3'd6) || (c.f3 == 3'd7);
      end
      6: begin
        w = fld((u >> 5) & 32'h7F, 25) | fld(c.rs2, 20) | fld(c.rs1, 15) | fld(c.f3, 12) |
            fld(u & 32'h1F, 7) | 32'h23;
        e = r12 || (c.f3 >= 3'd3);
      end
      7: begin
        if (c.f3 == 3'd1 || c.f3 == 3'd5) begin
          w = fld(c.f7, 25) | fld(u & 32'h1F, 20) | fld(c.rs1, 15) | fld(c.f3, 12) |
              fld(c.rd, 7) | 32'h13;
          e = (u > 31) || ((c.f3 == 3'd1) ? (c.f7 != 0) : (c.f7 != 0 && c.f7 != 7'd32));
        end else begin
          w = fld(u & 32'hFFF, 20) | fld(c.rs1, 15) | fld(c.f3, 12) | fld(c.rd, 7) | 32'h13;
          e = r12;
        end
      end
      8: begin
        w = fld(c.f7, 25) | fld(c.rs2, 20) | fld(c.rs1, 15) | fld(c.f3, 12) |
            fld(c.rd, 7) | 32'h33;
        e = !((c.f7 == 0) || (c.f7 == 7'd32 && (c.f3 == 3'd0 || c.f3 == 3'd5)));
      end
      9:  w = fld(u & 32'hFFF, 20) | 32'h0F;
      10: w = 32'h0000100F;
      11: w = 32'h00000073;
      12: w = 32'h00100073;
      13: begin
        w = fld(u & 32'hFFF, 20) | fld(c.rs1, 15) | fld(c.f3, 12) | fld(c.rd, 7) | 32'h73;
        e = (c.f3 == 3'd0) || (c.f3 == 3'd4);
      end
      default: e = 1'b1;
    endcase
    if (e) w = '0;
  endfunction

  function automatic cmd_t randCmd();
    cmd_t c;
    int   k;
    c.cls = 4'($urandom_range(0, 15));
    c.f3  = 3'($urandom);
    k = $urandom_range(0, 2);
    c.f7  = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom);
    c.rs1 = 5'($urandom);
    c.rs2 = 5'($urandom);
    c.rd  = 5'($urandom);
    case ($urandom_range(0, 4))
      0:       c.imm = $urandom;
      1:       c.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       c.imm = 32'($urandom_range(0, 40));
      3:       c.imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      default: c.imm = $urandom & 32'hFFFFF000;
    endcase
    return c;
  endfunction

  task automatic applyStimulus(input cmd_t c);
    enc_class  = c.cls;
    enc_funct3 = c.f3;
    enc_funct7 = c.f7;
    enc_rs1    = c.rs1;
    enc_rs2    = c.rs2;
    enc_rd     = c.rd;
    enc_imm    = c.imm;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic doReset();
    srst = 1'b1;
    enc_valid = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    srst = 1'b0;
  endtask

  function automatic logic [31:0] luiWord(input int i);
    return 32'((i + 1) << 12) | 32'((i + 1) << 7) | 32'h37;
  endfunction

  vector_t vec [19];
  entry_t  q [$];

  initial begin
    int          exp_ec;
    logic [31:0] w;
    logic        e;
    cmd_t        c;
    bit          push, pop;

    vec[0]  = '{mk(0, 0, 0, 0, 0, 5, 32'h12345000), 32'h123452B7, 1'b0};
    vec[1]  = '{mk(7, 0, 0, 0, 0, 1, 32'hFFFFFFFF), 32'hFFF00093, 1'b0};
    vec[2]  = '{mk(2, 0, 0, 0, 0, 1, 32'd8),        32'h008000EF, 1'b0};
    vec[3]  = '{mk(4, 0, 0, 1, 2, 0, 32'd16),       32'h00208863, 1'b0};
    vec[4]  = '{mk(4, 0, 0, 1, 2, 0, 32'd4096),     32'h00000000, 1'b1};
    vec[5]  = '{mk(2, 0, 0, 0, 0, 1, 32'd3),        32'h00000000, 1'b1};
    vec[6]  = '{mk(8, 0, 32, 1, 2, 3, 32'd0),       32'h402081B3, 1'b0};
    vec[7]  = '{mk(6, 2, 0, 1, 2, 0, 32'd8),        32'h0020A423, 1'b0};
    vec[8]  = '{mk(13, 1, 0, 2, 0, 1, 32'h300),     32'h300110F3, 1'b0};
    vec[9]  = '{mk(7, 5, 32, 2, 0, 1, 32'd3),       32'h40315093, 1'b0};
    vec[10] = '{mk(7, 1, 0, 2, 0, 1, 32'd32),       32'h00000000, 1'b1};
    vec[11] = '{mk(5, 3, 0, 2, 0, 1, 32'd0),        32'h00000000, 1'b1};
    vec[12] = '{mk(11, 3, 9, 4, 5, 7, 32'd5),       32'h00000073, 1'b0};
    vec[13] = '{mk(12, 0, 0, 0, 0, 0, 32'd0),       32'h00100073, 1'b0};
    vec[14] = '{mk(10, 0, 0, 0, 0, 0, 32'd0),       32'h0000100F, 1'b0};
    vec[15] = '{mk(15, 0, 0, 0, 0, 0, 32'd0),       32'h00000000, 1'b1};
    vec[16] = '{mk(0, 0, 0, 0, 0, 1, 32'h00001001), 32'h00000000, 1'b1};
    vec[17] = '{mk(5, 2, 0, 2, 0, 3, 32'hFFFFFFFC), 32'hFFC12183, 1'b0};
    vec[18] = '{mk(3, 0, 0, 1, 0, 0, 32'd0),        32'h00008067, 1'b0};

    doReset();
    checkOutput("reset_inst_valid", inst_valid, 0);
    checkOutput("reset_enc_ready", enc_ready, 1);
    checkOutput("reset_instruction", instruction, 0);
    checkOutput("reset_inst_error", inst_error, 0);
    checkOutput("reset_err_count", err_count, 0);

    exp_ec = 0;
    foreach (vec[i]) begin
      applyStimulus(vec[i].cmd);
      enc_valid = 1'b1;
      checkOutput($sformatf("vec%0d_pre_valid", i), inst_valid, 0);
      tick();
      enc_valid = 1'b0;
      if (vec[i].exp_err) exp_ec++;
      checkOutput($sformatf("vec%0d_valid", i), inst_valid, 1);
      checkOutput($sformatf("vec%0d_word", i), instruction, vec[i].exp_word);
      checkOutput($sformatf("vec%0d_error", i), inst_error, vec[i].exp_err);
      checkOutput($sformatf("vec%0d_err_count", i), err_count, exp_ec);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checkOutput($sformatf("vec%0d_drained", i), inst_valid, 0);
    end

    // Error counter saturation with continuous push+pop traffic.
    doReset();
    applyStimulus(mk(2, 0, 0, 0, 0, 1, 32'd3));
    enc_valid = 1'b1;
    inst_ready = 1'b1;
    tick();
    checkOutput("sat_first_count", err_count, 1);
    checkOutput("sat_first_word", instruction, 0);
    checkOutput("sat_first_error", inst_error, 1);
    for (int n = 2; n <= 300; n++) begin
      tick();
      if (n == 254) checkOutput("sat_count_254", err_count, 254);
      if (n == 255) checkOutput("sat_count_255", err_count, 255);
    end
    checkOutput("sat_count_300", err_count, 255);
    checkOutput("sat_ready_steady", enc_ready, 1);
    enc_valid = 1'b0;
    tick();
    tick();

    // Fill to full with the consumer stalled, then drain in order.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(0, 0, 0, 0, 0, i + 1, 32'((i + 1) << 12)));
      enc_valid = 1'b1;
      checkOutput($sformatf("fill%0d_ready", i), enc_ready, 1);
      tick();
    end
    applyStimulus(mk(0, 0, 0, 0, 0, 5, 32'(5 << 12)));
    checkOutput("full_ready_low", enc_ready, 0);
    checkOutput("full_head", instruction, luiWord(0));
    tick();
    checkOutput("full_hold_ready", enc_ready, 0);
    checkOutput("full_hold_head", instruction, luiWord(0));
    inst_ready = 1'b1;
    tick();
    checkOutput("pop1_ready", enc_ready, 1);
    checkOutput("pop1_head", instruction, luiWord(1));
    tick();
    enc_valid = 1'b0;
    checkOutput("pushpop_ready", enc_ready, 1);
    checkOutput("pushpop_head", instruction, luiWord(2));
    for (int i = 3; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("drain%0d_head", i), instruction, luiWord(i));
    end
    tick();
    checkOutput("drain_empty", inst_valid, 0);
    inst_ready = 1'b0;

    // Mid-operation reset flushes queued entries and the error count.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 1) ? mk(2, 0, 0, 0, 0, 1, 32'd3) : mk(0, 0, 0, 0, 0, 1, 32'h1000));
      enc_valid = 1'b1;
      tick();
    end
    enc_valid = 1'b0;
    checkOutput("prerst_err_count", err_count, 1);
    checkOutput("prerst_valid", inst_valid, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_enc_ready", enc_ready, 1);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_instruction", instruction, 0);
    checkOutput("rst_inst_error", inst_error, 0);
    tick();
    checkOutput("rst_stays_empty", inst_valid, 0);

    // Randomized traffic against the model and a scoreboard queue.
    doReset();
    q.delete();
    exp_ec = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      c = randCmd();
      applyStimulus(c);
      enc_valid  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      checkOutput("rnd_enc_ready", enc_ready, (q.size() < DEPTH));
      checkOutput("rnd_inst_valid", inst_valid, (q.size() > 0));
      if (q.size() > 0) begin
        checkOutput("rnd_instruction", instruction, q[0].word);
        checkOutput("rnd_inst_error", inst_error, q[0].err);
      end
      checkOutput("rnd_err_count", err_count, exp_ec);
      push = enc_valid && (q.size() < DEPTH);
      pop  = inst_ready && (q.size() > 0);
      model_encode(c, w, e);
      tick();
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{w, e});
        if (e && exp_ec < 255) exp_ec++;
      end
    end
    enc_valid = 1'b0;
    inst_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
